// File: rtl/frame_pkg.sv
// frame_pkg: shared constants, FSM state encoding and a saturating-increment
// helper for the sensor frame front end and its sibling statistics blocks.
//   FRAME_W   : assembled frame width {header, data, checksum}
//   HDR_BYTE  : default header byte
//   frame_state_e : sequencer states
//   sat_inc() : increment that holds at 'max' instead of wrapping
package frame_pkg;

  localparam int         FRAME_W  = 24;
  localparam logic [7:0] HDR_BYTE = 8'hAA;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    HDR  = 2'd1,
    DAT  = 2'd2
  } frame_state_e;

  // Counters up to 32 bits wide: callers zero-extend into 32 bits and
  // truncate the result back to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max);
    return (val >= max) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/byte_timeout_timer.sv
// byte_timeout_timer: inter-byte idle watchdog for the frame sequencer.
// Down-counter loaded with TIMEOUT_CYC-1; terminal count (zero) while
// running and not cleared raises expire_o for that cycle and reloads.
//   clk_i    : system clock
//   rst_i    : synchronous active-high reset
//   clear_i  : reload (byte accepted, or sequencer idle)
//   run_i    : count this cycle (frame partially collected)
//   expire_o : combinational, high in the cycle the idle limit is reached
module byte_timeout_timer #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int            CW   = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] remain_q, remain_d;

  // remain_q == LOAD - (idle cycles counted so far)
  assign expire_o = run_i & ~clear_i & (remain_q == '0);

  always_comb begin
    remain_d = remain_q;
    if (clear_i || expire_o) begin
      remain_d = LOAD;
    end else if (run_i) begin
      remain_d = remain_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      remain_q <= LOAD;
    end else begin
      remain_q <= remain_d;
    end
  end

endmodule

// File: rtl/frame_seq_ctrl.sv
// frame_seq_ctrl: front-end sequencer between the UART receiver and the
// 3-byte frame parser. Hunts for the header byte, assembles 24-bit frames,
// strobes valid_frame_o, collects the parser verdict one cycle later and
// keeps saturating statistics.
// Build option: define FRAME_TIMEOUT_EN to abort partial frames after
// TIMEOUT_CYC idle cycles; undefined, a partial frame waits indefinitely.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   rx_valid_i/byte_i : received byte strobe and data
//   parser_valid_i    : parser accept flag, one cycle after valid_frame_o
//   frame_o           : {header, data, checksum}
//   valid_frame_o     : one-cycle frame strobe
//   busy_o            : partial frame in progress
//   timeout_err_o     : one-cycle pulse on timeout abort
//   good_cnt_o, chk_err_cnt_o, drop_cnt_o : saturating statistics
//
// state | meaning
// HUNT  | waiting for header byte, other bytes dropped
// HDR   | header stored, waiting for data byte
// DAT   | data stored, waiting for checksum byte
module frame_seq_ctrl
  import frame_pkg::*;
#(
  parameter logic [7:0] HEADER      = HDR_BYTE,
  parameter int         TIMEOUT_CYC = 50000,
  parameter int         CNT_W       = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               rx_valid_i,
  input  logic [7:0]         rx_byte_i,
  input  logic               parser_valid_i,
  output logic [FRAME_W-1:0] frame_o,
  output logic               valid_frame_o,
  output logic               busy_o,
  output logic               timeout_err_o,
  output logic [CNT_W-1:0]   good_cnt_o,
  output logic [CNT_W-1:0]   chk_err_cnt_o,
  output logic [CNT_W-1:0]   drop_cnt_o
);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be >= 2");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("CNT_W must be 1..32");
  end

  localparam logic [1:0]       ST_HUNT = HUNT;
  localparam logic [1:0]       ST_HDR  = HDR;
  localparam logic [1:0]       ST_DAT  = DAT;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]         state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               valid_q, valid_d;
  logic               pending_q;
  logic [CNT_W-1:0]   good_q, good_d;
  logic [CNT_W-1:0]   chk_q, chk_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic               drop_inc;
  logic               expire;

`ifdef FRAME_TIMEOUT_EN
  logic tout_q;

  byte_timeout_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (rx_valid_i | (state_q == ST_HUNT)),
    .run_i    (state_q != ST_HUNT),
    .expire_o (expire)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) tout_q <= 1'b0;
    else       tout_q <= expire;
  end

  assign timeout_err_o = tout_q;
`else
  assign expire        = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  // A byte in the expiry cycle takes priority: expire is already masked by
  // rx_valid inside the timer, and each branch tests rx_valid first anyway.
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    valid_d  = 1'b0;
    drop_inc = 1'b0;
    case (state_q)
      ST_HUNT: begin
        if (rx_valid_i) begin
          if (rx_byte_i == HEADER) begin
            state_d        = ST_HDR;
            frame_d[23:16] = rx_byte_i;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      ST_HDR: begin
        if (rx_valid_i) begin
          state_d       = ST_DAT;
          frame_d[15:8] = rx_byte_i;
        end else if (expire) begin
          state_d  = ST_HUNT;
          drop_inc = 1'b1;
        end
      end
      ST_DAT: begin
        if (rx_valid_i) begin
          state_d      = ST_HUNT;
          frame_d[7:0] = rx_byte_i;
          valid_d      = 1'b1;
        end else if (expire) begin
          state_d  = ST_HUNT;
          drop_inc = 1'b1;
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_comb begin
    good_d = good_q;
    chk_d  = chk_q;
    drop_d = drop_q;
    if (pending_q && parser_valid_i)
      good_d = CNT_W'(sat_inc(32'(good_q), 32'(CNT_MAX)));
    if (pending_q && !parser_valid_i)
      chk_d = CNT_W'(sat_inc(32'(chk_q), 32'(CNT_MAX)));
    if (drop_inc)
      drop_d = CNT_W'(sat_inc(32'(drop_q), 32'(CNT_MAX)));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_HUNT;
      frame_q   <= '0;
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
      good_q    <= '0;
      chk_q     <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      valid_q   <= valid_d;
      pending_q <= valid_q;
      good_q    <= good_d;
      chk_q     <= chk_d;
      drop_q    <= drop_d;
    end
  end

  assign frame_o       = frame_q;
  assign valid_frame_o = valid_q;
  assign busy_o        = (state_q != ST_HUNT);
  assign good_cnt_o    = good_q;
  assign chk_err_cnt_o = chk_q;
  assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
module tb_frame_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        parser_valid = 1'b0;
  logic [23:0] frame;
  logic        valid_frame, busy, timeout_err;
  logic [3:0]  good_cnt, chk_err_cnt, drop_cnt;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  frame_seq_ctrl #(
    .HEADER      (8'hAA),
    .TIMEOUT_CYC (8),
    .CNT_W       (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rx_valid_i     (rx_valid),
    .rx_byte_i      (rx_byte),
    .parser_valid_i (parser_valid),
    .frame_o        (frame),
    .valid_frame_o  (valid_frame),
    .busy_o         (busy),
    .timeout_err_o  (timeout_err),
    .good_cnt_o     (good_cnt),
    .chk_err_cnt_o  (chk_err_cnt),
    .drop_cnt_o     (drop_cnt)
  );

  // Drive one cycle of input, then observe just after the consuming edge.
  task automatic step(input logic v, input logic [7:0] b);
    @(negedge clk);
    rx_valid = v;
    rx_byte  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    if (frame !== 24'h0) begin errors++; $display("FAIL rst_frame: got %h want %h", frame, 24'h0); end
    vectors++;
    if (valid_frame !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid_frame); end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_tout: got %b want 0", timeout_err); end
    vectors++;
    if ({good_cnt, chk_err_cnt, drop_cnt} !== 12'h000) begin
      errors++; $display("FAIL rst_cnts: got %h %h %h want 0 0 0", good_cnt, chk_err_cnt, drop_cnt);
    end
    vectors++;
  endtask

  task automatic test_good_frame;
    do_reset();
    parser_valid = 1'b1;
    step(1'b1, 8'hAA);
    if (busy !== 1'b1) begin errors++; $display("FAIL good_busy_hdr: got %b want 1", busy); end
    vectors++;
    step(1'b1, 8'h3C);
    if (valid_frame !== 1'b0) begin errors++; $display("FAIL good_valid_early: got %b want 0", valid_frame); end
    vectors++;
    step(1'b1, 8'h3C);
    if (valid_frame !== 1'b1) begin errors++; $display("FAIL good_valid: got %b want 1", valid_frame); end
    vectors++;
    if (frame !== 24'hAA3C3C) begin errors++; $display("FAIL good_frame: got %h want %h", frame, 24'hAA3C3C); end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_done: got %b want 0", busy); end
    vectors++;
    step(1'b0, 8'h00);
    if (valid_frame !== 1'b0) begin errors++; $display("FAIL good_valid_pulse: got %b want 0", valid_frame); end
    vectors++;
    if (good_cnt !== 4'd0) begin errors++; $display("FAIL good_cnt_early: got %0d want 0", good_cnt); end
    vectors++;
    step(1'b0, 8'h00);
    if (good_cnt !== 4'd1) begin errors++; $display("FAIL good_cnt: got %0d want 1", good_cnt); end
    vectors++;
    if (chk_err_cnt !== 4'd0) begin errors++; $display("FAIL good_chk: got %0d want 0", chk_err_cnt); end
    vectors++;
    if (frame !== 24'hAA3C3C) begin errors++; $display("FAIL good_frame_hold: got %h want %h", frame, 24'hAA3C3C); end
    vectors++;
  endtask

  task automatic test_hunt;
    do_reset();
    parser_valid = 1'b0;
    step(1'b1, 8'h12);
    if (drop_cnt !== 4'd1) begin errors++; $display("FAIL hunt_drop1: got %0d want 1", drop_cnt); end
    vectors++;
    step(1'b1, 8'h55);
    step(1'b1, 8'hAA);
    step(1'b1, 8'h07);
    step(1'b1, 8'h08);
    if (valid_frame !== 1'b1) begin errors++; $display("FAIL hunt_valid: got %b want 1", valid_frame); end
    vectors++;
    if (frame !== 24'hAA0708) begin errors++; $display("FAIL hunt_frame: got %h want %h", frame, 24'hAA0708); end
    vectors++;
    idle(2);
    if (drop_cnt !== 4'd2) begin errors++; $display("FAIL hunt_drop: got %0d want 2", drop_cnt); end
    vectors++;
    if (chk_err_cnt !== 4'd1) begin errors++; $display("FAIL hunt_chk: got %0d want 1", chk_err_cnt); end
    vectors++;
    if (good_cnt !== 4'd0) begin errors++; $display("FAIL hunt_good: got %0d want 0", good_cnt); end
    vectors++;
  endtask

  task automatic test_back_to_back;
    do_reset();
    parser_valid = 1'b0;
    step(1'b1, 8'hAA);
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    step(1'b1, 8'h33);
    step(1'b1, 8'h44);
    // verdict and a hunt drop land on the same edge
    if (drop_cnt !== 4'd2) begin errors++; $display("FAIL b2b_drop: got %0d want 2", drop_cnt); end
    vectors++;
    if (chk_err_cnt !== 4'd1) begin errors++; $display("FAIL b2b_chk: got %0d want 1", chk_err_cnt); end
    vectors++;
    parser_valid = 1'b1;
    step(1'b1, 8'hAA);
    step(1'b1, 8'h05);
    step(1'b1, 8'h06);
    step(1'b1, 8'hAA);
    step(1'b1, 8'h07);
    if (good_cnt !== 4'd1) begin errors++; $display("FAIL b2b_good1: got %0d want 1", good_cnt); end
    vectors++;
    step(1'b1, 8'h08);
    if (frame !== 24'hAA0708 || valid_frame !== 1'b1) begin
      errors++; $display("FAIL b2b_frame2: got %h/%b want %h/1", frame, valid_frame, 24'hAA0708);
    end
    vectors++;
    idle(2);
    if (good_cnt !== 4'd2) begin errors++; $display("FAIL b2b_good2: got %0d want 2", good_cnt); end
    vectors++;
  endtask

`ifdef FRAME_TIMEOUT_EN
  task automatic test_timeout;
    do_reset();
    parser_valid = 1'b1;
    step(1'b1, 8'hAA);
    step(1'b1, 8'h11);
    idle(7);
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL tout_early: got busy=%b tout=%b want 1 0", busy, timeout_err);
    end
    vectors++;
    idle(1);
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL tout_pulse: got %b want 1", timeout_err); end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL tout_busy: got %b want 0", busy); end
    vectors++;
    if (drop_cnt !== 4'd1) begin errors++; $display("FAIL tout_drop: got %0d want 1", drop_cnt); end
    vectors++;
    step(1'b1, 8'hAA);
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL tout_after: got tout=%b busy=%b want 0 1", timeout_err, busy);
    end
    vectors++;
    step(1'b1, 8'h22);
    step(1'b1, 8'h22);
    if (frame !== 24'hAA2222 || valid_frame !== 1'b1) begin
      errors++; $display("FAIL tout_frame: got %h/%b want %h/1", frame, valid_frame, 24'hAA2222);
    end
    vectors++;
  endtask

  task automatic test_expiry_byte;
    do_reset();
    step(1'b1, 8'hAA);
    idle(7);
    step(1'b1, 8'h55);
    if (busy !== 1'b1 || timeout_err !== 1'b0 || drop_cnt !== 4'd0) begin
      errors++; $display("FAIL exp_byte: got busy=%b tout=%b drop=%0d want 1 0 0", busy, timeout_err, drop_cnt);
    end
    vectors++;
    step(1'b1, 8'h66);
    if (frame !== 24'hAA5566 || valid_frame !== 1'b1) begin
      errors++; $display("FAIL exp_frame: got %h/%b want %h/1", frame, valid_frame, 24'hAA5566);
    end
    vectors++;
  endtask
`else
  task automatic test_no_timeout;
    do_reset();
    step(1'b1, 8'hAA);
    idle(20);
    if (busy !== 1'b1 || timeout_err !== 1'b0 || drop_cnt !== 4'd0) begin
      errors++; $display("FAIL notout_wait: got busy=%b tout=%b drop=%0d want 1 0 0", busy, timeout_err, drop_cnt);
    end
    vectors++;
    step(1'b1, 8'h55);
    step(1'b1, 8'h66);
    if (frame !== 24'hAA5566 || valid_frame !== 1'b1) begin
      errors++; $display("FAIL notout_frame: got %h/%b want %h/1", frame, valid_frame, 24'hAA5566);
    end
    vectors++;
  endtask
`endif

  task automatic test_saturate;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(i + 1));
      if (i == 13) begin
        if (drop_cnt !== 4'hE) begin errors++; $display("FAIL sat_14: got %h want E", drop_cnt); end
        vectors++;
      end
      if (i == 14) begin
        if (drop_cnt !== 4'hF) begin errors++; $display("FAIL sat_15: got %h want F", drop_cnt); end
        vectors++;
      end
    end
    if (drop_cnt !== 4'hF) begin errors++; $display("FAIL sat_20: got %h want F", drop_cnt); end
    vectors++;
  endtask

  task automatic test_rst_mid;
    do_reset();
    parser_valid = 1'b1;
    step(1'b1, 8'hAA);
    step(1'b1, 8'h10);
    do_reset();
    if (busy !== 1'b0 || frame !== 24'h0) begin
      errors++; $display("FAIL rstmid_clear: got busy=%b frame=%h want 0 000000", busy, frame);
    end
    vectors++;
    step(1'b1, 8'h10);
    step(1'b1, 8'hAA);
    step(1'b1, 8'h05);
    step(1'b1, 8'h05);
    if (frame !== 24'hAA0505 || valid_frame !== 1'b1) begin
      errors++; $display("FAIL rstmid_frame: got %h/%b want %h/1", frame, valid_frame, 24'hAA0505);
    end
    vectors++;
    if (drop_cnt !== 4'd1) begin errors++; $display("FAIL rstmid_drop: got %0d want 1", drop_cnt); end
    vectors++;
    // reset in the strobe cycle: the pending verdict is lost
    do_reset();
    idle(2);
    if ({good_cnt, chk_err_cnt, drop_cnt} !== 12'h000) begin
      errors++; $display("FAIL rstmid_pending: got %h %h %h want 0 0 0", good_cnt, chk_err_cnt, drop_cnt);
    end
    vectors++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_good_frame();
    test_hunt();
    test_back_to_back();
`ifdef FRAME_TIMEOUT_EN
    test_timeout();
    test_expiry_byte();
`else
    test_no_timeout();
`endif
    test_saturate();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/frame_seq_ctrl.md
Name: frame_seq_ctrl

Overview:
- Front-end sequencer for the 3-byte sensor frame parser.
- Accepts a raw received byte stream, hunts for the header byte and assembles 24-bit frames. Issues a single-cycle frame strobe to the parser and tracks the parser's verdict.
- Aborts partial frames on an inter-byte timeout and keeps saturating statistics counters.
- Sits between the UART receiver and the frame parser.

Parameters:
- HEADER, 8'hAA, header byte expected in frame[23:16]
- TIMEOUT_CYC, 50000, max idle cycles allowed between bytes of one frame (must be >= 2)
- CNT_W, 16, width of statistics counters

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- rx_valid  in  1  one-cycle strobe: rx_byte holds a new byte
- rx_byte  in  8  received byte
- parser_valid  in  1  parser result flag, valid one cycle after valid_frame
- frame  out  24  assembled frame {header, data, checksum}, held until the next emission
- valid_frame  out  1  one-cycle strobe to parser
- busy  out  1  high while a frame is partially collected
- timeout_err  out  1  one-cycle pulse on a timeout abort
- good_cnt  out  CNT_W  frames accepted by parser
- chk_err_cnt  out  CNT_W  frames emitted but rejected by parser
- drop_cnt  out  CNT_W  bytes discarded while hunting, plus aborted frames

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - frame=0, valid_frame=0, busy=0, timeout_err=0.
  - All counters=0; state=HUNT; timer=0; pending=0.
- States: HUNT, HDR (header received), DAT (data byte received). busy = (state != HUNT).
- HUNT:
  - rx_valid && rx_byte==HEADER -> HDR; frame[23:16] <= rx_byte.
  - rx_valid && other byte -> stay; drop_cnt++.
- HDR: rx_valid -> DAT; frame[15:8] <= rx_byte. The byte is not header-checked, so data 8'hAA is legal.
- DAT: rx_valid -> HUNT; frame[7:0] <= rx_byte; valid_frame=1 in the next cycle.
- Latency: valid_frame rises exactly 1 cycle after the third byte's rx_valid cycle. frame is stable from that cycle on.
- Verdict:
  - pending is set in the valid_frame cycle.
  - In the following cycle: parser_valid=1 -> good_cnt++; else chk_err_cnt++. pending then clears.
  - A new frame needs at least 3 rx_valid cycles, so pending never overlaps.
- Timer:
  - Resets to 0 on every accepted rx_valid and in HUNT.
  - Otherwise increments in HDR/DAT.
  - When timer == TIMEOUT_CYC-1 with no rx_valid that cycle: state -> HUNT, timeout_err pulses next cycle, drop_cnt++, timer=0.
- Simultaneous byte and timeout in the same cycle: the byte wins; no timeout.
- A byte arriving in the cycle right after a timeout abort is treated in HUNT.
- Counters saturate at all-ones and never wrap.
- If more than one counter increments in the same cycle, each updates independently.
- rst mid-frame: the partial frame is discarded and a pending verdict is lost. Nothing is counted.

Optional Feature:
- FRAME_TIMEOUT_EN
- Defined: inter-byte timeout as above.
- Undefined: no timer logic; timeout_err tied 0; a partial frame waits indefinitely for its remaining bytes.

Decomposition:
- Shared package frame_pkg:
  - constants FRAME_W=24 and HDR_BYTE=8'hAA.
  - state enum {HUNT, HDR, DAT}.
  - a saturating-increment function, reused by other stat blocks.
- One sub-module: byte_timeout_timer.
  - Inputs: clk, rst, clear, run.
  - Output: expire.
  - Parameter: TIMEOUT_CYC.
  - Instantiated only under FRAME_TIMEOUT_EN.

Test Plan:
- Bytes AA,3C,3C back-to-back, parser_valid=1 next cycle -> frame=24'hAA3C3C, valid_frame one pulse 1 cycle after 3rd byte, good_cnt=1.
- Bytes 12,55,AA,07,08, parser_valid=0 -> drop_cnt=2, frame=24'hAA0708, chk_err_cnt=1.
- TIMEOUT_CYC=8: AA,11 then idle 8 cycles -> timeout_err pulse, drop_cnt=1, busy=0; following AA,22,22 -> frame AA2222 emitted.
- TIMEOUT_CYC=8: AA, then next byte on the exact expiry cycle -> no timeout; state DAT.
- CNT_W=4: 20 non-header bytes -> drop_cnt saturates at 4'hF.
- AA,10 then rst=1 one cycle, then 10,AA,05,05 -> first bytes lost, drop_cnt=1 (for 10), frame=AA0505.
